// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store memory port: RAM access modes,
// the latched access descriptor and small lane-mapping helpers.
package lsu_mem_port_pkg;

    // RAM access size codes, shared with the instruction decoder
    localparam logic [1:0] RAM_MODE_NONE = 2'd0;
    localparam logic [1:0] RAM_MODE_BYTE = 2'd1;
    localparam logic [1:0] RAM_MODE_HALF = 2'd2;
    localparam logic [1:0] RAM_MODE_WORD = 2'd3;

    // Everything about an accepted request that later phases still need
    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       sgn;
        logic       split;
    } acc_info_t;

    // Byte-lane mask across two consecutive words: bits [3:0] are the low
    // word, bits [7:4] the following word.
    function automatic logic [7:0] lane_mask8(input logic [1:0] off, input logic [1:0] size);
        logic [7:0] base;
        case (size)
            RAM_MODE_BYTE: base = 8'h01;
            RAM_MODE_HALF: base = 8'h03;
            RAM_MODE_WORD: base = 8'h0F;
            default:       base = 8'h00;
        endcase
        return base << off;
    endfunction

    // Rotate store data left by whole bytes so byte 0 lands on lane 'off'.
    // The lanes that spill past lane 3 wrap to the low lanes, which is
    // exactly what the second word of a split store needs.
    function automatic logic [31:0] rotl_bytes(input logic [31:0] data, input logic [1:0] off);
        case (off)
            2'd1:    return {data[23:0], data[31:24]};
            2'd2:    return {data[15:0], data[31:16]};
            2'd3:    return {data[7:0],  data[31:8]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_load_align_ext.sv
// Load data aligner: takes up to two RAM words as one 64-bit value, shifts
// the addressed bytes down to bit 0 and sign- or zero-extends the result.
module lsu_mem_port_load_align_ext
    import lsu_mem_port_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] result_o
);

    logic [31:0] lowWord;

    assign lowWord = 32'(data_i >> {off_i, 3'b000});

    // Keep the low n bytes and extend according to the requested signedness
    always_comb begin
        result_o = 32'h0;
        case (size_i)
            RAM_MODE_BYTE: result_o = {{24{signed_i & lowWord[7]}}, lowWord[7:0]};
            RAM_MODE_HALF: result_o = {{16{signed_i & lowWord[15]}}, lowWord[15:0]};
            RAM_MODE_WORD: result_o = lowWord;
            default:       result_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Data-memory access unit between execute and a word-wide, byte-enabled
// synchronous RAM. Loads return aligned, extended data; accesses that cross
// a word boundary are split into two RAM accesses.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        read_size,
    input  logic [1:0]        write_size,
    input  logic              read_signed,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LD_DATA = 2'd1;
    localparam logic [1:0] ST_LD_HI   = 2'd2;
    localparam logic [1:0] ST_ST_HI   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wordAddr_q;
    acc_info_t         info_q;
    logic [3:0]        hiBe_q;
    logic [31:0]       wdataRot_q;
    logic [31:0]       loWord_q;
    logic [31:0]       rdata_q;
    logic              rdataValid_q;

    logic              isLoad;
    logic              isStore;
    logic [1:0]        reqSize;
    logic [7:0]        reqMask;
    logic              reqSplit;
    logic [ADDR_W-1:0] reqWord;
    logic [ADDR_W-1:0] nextWord;
    logic [31:0]       reqWdataRot;
    logic              accept;
    logic [63:0]       alignIn;
    logic [31:0]       alignResult;
    logic              unusedAddrBits;

    assign isLoad         = (read_size != RAM_MODE_NONE);
    assign isStore        = (write_size != RAM_MODE_NONE) && !isLoad;
    assign reqSize        = isLoad ? read_size : write_size;
    assign reqMask        = lane_mask8(addr[1:0], reqSize);
    assign reqSplit       = |reqMask[7:4];
    assign reqWord        = addr[ADDR_W+1:2];
    assign nextWord       = wordAddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign reqWdataRot    = rotl_bytes(wdata, addr[1:0]);
    assign accept         = req_valid & req_ready;
    assign unusedAddrBits = ^addr[31:ADDR_W+2];

    assign alignIn = info_q.split ? {ram_rdata, loWord_q} : {32'h0, ram_rdata};

    lsu_mem_port_load_align_ext u_align (
        .data_i   (alignIn),
        .off_i    (info_q.off),
        .size_i   (info_q.size),
        .signed_i (info_q.sgn),
        .result_o (alignResult)
    );

    assign rdata       = rdata_q;
    assign rdata_valid = rdataValid_q;

    // Next state and RAM port drive; reset suppresses handshake and writes
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ram_addr  = wordAddr_q;
        ram_we    = 1'b0;
        ram_be    = 4'h0;
        ram_wdata = wdataRot_q;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                ram_addr  = reqWord;
                ram_wdata = reqWdataRot;
                if (req_valid) begin
                    if (isStore) begin
                        ram_we  = 1'b1;
                        ram_be  = reqMask[3:0];
                        state_d = reqSplit ? ST_ST_HI : ST_IDLE;
                    end else if (isLoad) begin
                        ram_be  = reqMask[3:0];
                        state_d = reqSplit ? ST_LD_HI : ST_LD_DATA;
                    end
                end
            end
            ST_ST_HI: begin
                ram_addr = nextWord;
                ram_we   = 1'b1;
                ram_be   = hiBe_q;
                state_d  = ST_IDLE;
            end
            ST_LD_HI: begin
                ram_addr = nextWord;
                ram_be   = hiBe_q;
                state_d  = ST_LD_DATA;
            end
            ST_LD_DATA: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            req_ready = 1'b0;
            ram_we    = 1'b0;
            ram_be    = 4'h0;
            state_d   = ST_IDLE;
        end
    end

    // Latch the request, collect the low word of a split load, register results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wordAddr_q   <= '0;
            info_q       <= '0;
            hiBe_q       <= 4'h0;
            wdataRot_q   <= 32'h0;
            loWord_q     <= 32'h0;
            rdata_q      <= 32'h0;
            rdataValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdataValid_q <= 1'b0;
            if (accept) begin
                wordAddr_q <= reqWord;
                info_q     <= '{off: addr[1:0], size: reqSize, sgn: read_signed, split: reqSplit};
                hiBe_q     <= reqMask[7:4];
                wdataRot_q <= reqWdataRot;
            end
            if (state_q == ST_LD_HI) begin
                loWord_q <= ram_rdata;
            end
            if (state_q == ST_LD_DATA) begin
                rdata_q      <= alignResult;
                rdataValid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: a word RAM model on the memory side, a
// byte-addressed reference memory, table vectors, hand-timed sequences for
// split/wrap/reset corners, then randomized accesses.
module tb_lsu_mem_port;
    import lsu_mem_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  read_size;
    logic [1:0]  write_size;
    logic        read_signed;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ramRdata;

    int total = 0;
    int bad = 0;
    int loadsIssued = 0;
    int validPulses = 0;

    logic [31:0] ramMem [0:16383];
    logic [7:0]  refMem [0:65535];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rs;
        logic [1:0]  ws;
        logic        sg;
        logic [31:0] expRdata;
        int          expLat;
    } vec_t;

    vec_t vecs [20];

    lsu_mem_port #(.ADDR_W(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .addr        (addr),
        .wdata       (wdata),
        .read_size   (read_size),
        .write_size  (write_size),
        .read_signed (read_signed),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_be      (ram_be),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ramRdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency and byte-lane writes
    always @(posedge clk) begin
        ramRdata <= ramMem[ram_addr];
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) ramMem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Count result pulses so stray or stretched rdata_valid shows up
    always @(negedge clk) begin
        if (rdata_valid) validPulses++;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] m);
        case (m)
            RAM_MODE_BYTE: return 1;
            RAM_MODE_HALF: return 2;
            default:       return 4;
        endcase
    endfunction

    // Reference model on a flat little-endian byte memory (16-bit byte space)
    task automatic modelAccess(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs,
                               input logic [1:0] ws, input logic sg,
                               output logic [31:0] exp, output int expLat);
        int n;
        int off;
        logic [63:0] v;
        exp = 32'h0;
        expLat = 0;
        off = int'(a[1:0]);
        if (rs != RAM_MODE_NONE) begin
            n = sizeBytes(rs);
            v = 64'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[16'(a[15:0] + i)];
            if (sg && v[8*n-1]) begin
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            exp = v[31:0];
            expLat = (off + n > 4) ? 3 : 2;
        end else if (ws != RAM_MODE_NONE) begin
            n = sizeBytes(ws);
            for (int i = 0; i < n; i++) refMem[16'(a[15:0] + i)] = d[8*i +: 8];
        end
    endtask

    task automatic driveReq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs,
                            input logic [1:0] ws, input logic sg);
        req_valid = 1'b1;
        addr = a;
        wdata = d;
        read_size = rs;
        write_size = ws;
        read_signed = sg;
    endtask

    // Drop the request and scramble the inputs so only latched copies matter
    task automatic idleInputs();
        req_valid = 1'b0;
        addr = $urandom;
        wdata = $urandom;
        read_size = 2'($urandom_range(0, 3));
        write_size = 2'($urandom_range(0, 3));
        read_signed = 1'($urandom_range(0, 1));
    endtask

    // Advance to a negedge where the unit is ready (bounded)
    task automatic waitReady();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) checkOutput("ready_timeout", {31'b0, req_ready}, 32'h1);
    endtask

    // One complete access; for loads returns data and cycles to rdata_valid
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs,
                                 input logic [1:0] ws, input logic sg,
                                 output logic [31:0] got, output int lat,
                                 output logic [31:0] modelExp, output int modelLat);
        modelAccess(a, d, rs, ws, sg, modelExp, modelLat);
        waitReady();
        driveReq(a, d, rs, ws, sg);
        @(negedge clk);
        idleInputs();
        got = 32'h0;
        lat = 0;
        if (rs != RAM_MODE_NONE) begin
            loadsIssued++;
            lat = 1;
            while (!rdata_valid && lat < 6) begin
                @(negedge clk);
                lat++;
            end
            got = rdata;
        end
    endtask

    initial begin
        logic [31:0] got, mExp, a, d;
        logic [1:0]  rs, ws;
        logic        sg;
        int          lat, mLat;

        for (int i = 0; i < 65536; i++) refMem[i] = 8'h00;

        vecs[0]  = '{32'h100, 32'h0,        RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, 32'hDEADBEEF, 2};
        vecs[1]  = '{32'h100, 32'h80FF0000, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, 32'h0,        0};
        vecs[2]  = '{32'h103, 32'h0,        RAM_MODE_BYTE, RAM_MODE_NONE, 1'b1, 32'hFFFFFF80, 2};
        vecs[3]  = '{32'h103, 32'h0,        RAM_MODE_BYTE, RAM_MODE_NONE, 1'b0, 32'h00000080, 2};
        vecs[4]  = '{32'h102, 32'h0,        RAM_MODE_HALF, RAM_MODE_NONE, 1'b1, 32'hFFFF80FF, 2};
        vecs[5]  = '{32'h100, 32'h44332211, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, 32'h0,        0};
        vecs[6]  = '{32'h104, 32'h88776655, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, 32'h0,        0};
        vecs[7]  = '{32'h102, 32'h0,        RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, 32'h66554433, 3};
        vecs[8]  = '{32'h101, 32'h0,        RAM_MODE_HALF, RAM_MODE_NONE, 1'b0, 32'h00003322, 2};
        vecs[9]  = '{32'h105, 32'h0,        RAM_MODE_BYTE, RAM_MODE_NONE, 1'b1, 32'h00000066, 2};
        vecs[10] = '{32'h107, 32'h0,        RAM_MODE_BYTE, RAM_MODE_NONE, 1'b1, 32'hFFFFFF88, 2};
        vecs[11] = '{32'h106, 32'h123456AA, RAM_MODE_NONE, RAM_MODE_BYTE, 1'b0, 32'h0,        0};
        vecs[12] = '{32'h104, 32'h0,        RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, 32'h88AA6655, 2};
        vecs[13] = '{32'h103, 32'h0000ABCD, RAM_MODE_NONE, RAM_MODE_HALF, 1'b0, 32'h0,        0};
        vecs[14] = '{32'h100, 32'h0,        RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, 32'hCD332211, 2};
        vecs[15] = '{32'h104, 32'h0,        RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, 32'h88AA66AB, 2};
        vecs[16] = '{32'h103, 32'h0,        RAM_MODE_HALF, RAM_MODE_NONE, 1'b1, 32'hFFFFABCD, 3};
        vecs[17] = '{32'h100, 32'h5A5A5A5A, RAM_MODE_NONE, RAM_MODE_NONE, 1'b0, 32'h0,        0};
        vecs[18] = '{32'h100, 32'hFFFFFFFF, RAM_MODE_WORD, RAM_MODE_WORD, 1'b0, 32'hCD332211, 2};
        vecs[19] = '{32'h100, 32'h0,        RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, 32'hCD332211, 2};

        // Reset state
        rst = 1'b1;
        idleInputs();
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h0);
        checkOutput("rst_ram_we", {31'b0, ram_we}, 32'h0);
        checkOutput("rst_ram_be", {28'b0, ram_be}, 32'h0);
        checkOutput("rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        idleInputs();
        rst = 1'b0;

        // Aligned store drives the RAM in the acceptance cycle
        waitReady();
        driveReq(32'h100, 32'hDEADBEEF, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0);
        modelAccess(32'h100, 32'hDEADBEEF, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, mExp, mLat);
        #1;
        checkOutput("sw_ram_we", {31'b0, ram_we}, 32'h1);
        checkOutput("sw_ram_be", {28'b0, ram_be}, 32'hF);
        checkOutput("sw_ram_addr", {18'b0, ram_addr}, 32'h40);
        checkOutput("sw_ram_wdata", ram_wdata, 32'hDEADBEEF);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("sw_ready_next", {31'b0, req_ready}, 32'h1);

        // Table vectors
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].rs, vecs[i].ws, vecs[i].sg,
                          got, lat, mExp, mLat);
            if (vecs[i].rs != RAM_MODE_NONE) begin
                checkOutput($sformatf("vec%0d_rdata", i), got, vecs[i].expRdata);
                checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
            end
        end

        // Split halfword store: two writes with the same rotated data
        waitReady();
        driveReq(32'h103, 32'h0000ABCD, RAM_MODE_NONE, RAM_MODE_HALF, 1'b0);
        modelAccess(32'h103, 32'h0000ABCD, RAM_MODE_NONE, RAM_MODE_HALF, 1'b0, mExp, mLat);
        #1;
        checkOutput("sh_t0_addr", {18'b0, ram_addr}, 32'h40);
        checkOutput("sh_t0_be", {28'b0, ram_be}, 32'h8);
        checkOutput("sh_t0_we", {31'b0, ram_we}, 32'h1);
        checkOutput("sh_t0_wdata", ram_wdata, 32'hCD0000AB);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("sh_t1_addr", {18'b0, ram_addr}, 32'h41);
        checkOutput("sh_t1_be", {28'b0, ram_be}, 32'h1);
        checkOutput("sh_t1_we", {31'b0, ram_we}, 32'h1);
        checkOutput("sh_t1_wdata", ram_wdata, 32'hCD0000AB);
        checkOutput("sh_t1_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("sh_t2_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("sh_t2_we", {31'b0, ram_we}, 32'h0);

        // Split word load timing
        applyStimulus(32'h100, 32'h44332211, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, got, lat, mExp, mLat);
        applyStimulus(32'h104, 32'h88776655, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, got, lat, mExp, mLat);
        waitReady();
        driveReq(32'h102, 32'h0, RAM_MODE_WORD, RAM_MODE_NONE, 1'b0);
        loadsIssued++;
        #1;
        checkOutput("lw_t0_addr", {18'b0, ram_addr}, 32'h40);
        checkOutput("lw_t0_we", {31'b0, ram_we}, 32'h0);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("lw_t1_addr", {18'b0, ram_addr}, 32'h41);
        checkOutput("lw_t1_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("lw_t2_ready", {31'b0, req_ready}, 32'h0);
        checkOutput("lw_t2_valid", {31'b0, rdata_valid}, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("lw_t3_valid", {31'b0, rdata_valid}, 32'h1);
        checkOutput("lw_t3_rdata", rdata, 32'h66554433);
        checkOutput("lw_t3_ready", {31'b0, req_ready}, 32'h1);

        // Split load at the top word wraps to word 0
        applyStimulus(32'hFFFC, 32'hA1B2C3D4, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, got, lat, mExp, mLat);
        applyStimulus(32'h0000, 32'h11223344, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, got, lat, mExp, mLat);
        waitReady();
        driveReq(32'hFFFD, 32'h0, RAM_MODE_WORD, RAM_MODE_NONE, 1'b0);
        loadsIssued++;
        #1;
        checkOutput("wrap_t0_addr", {18'b0, ram_addr}, 32'h3FFF);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("wrap_t1_addr", {18'b0, ram_addr}, 32'h0000);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("wrap_valid", {31'b0, rdata_valid}, 32'h1);
        checkOutput("wrap_rdata", rdata, 32'h44A1B2C3);

        // Reset in the second phase of a split store drops the high write
        applyStimulus(32'h200, 32'h0, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, got, lat, mExp, mLat);
        applyStimulus(32'h204, 32'h0, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0, got, lat, mExp, mLat);
        waitReady();
        driveReq(32'h201, 32'hAABBCCDD, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0);
        #1;
        checkOutput("rstsplit_t0_be", {28'b0, ram_be}, 32'hE);
        @(negedge clk);
        idleInputs();
        rst = 1'b1;
        #1;
        checkOutput("rstsplit_t1_we", {31'b0, ram_we}, 32'h0);
        checkOutput("rstsplit_t1_be", {28'b0, ram_be}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstsplit_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rstsplit_valid", {31'b0, rdata_valid}, 32'h0);
        refMem[16'h201] = 8'hDD;
        refMem[16'h202] = 8'hCC;
        refMem[16'h203] = 8'hBB;
        applyStimulus(32'h200, 32'h0, RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, got, lat, mExp, mLat);
        checkOutput("rstsplit_lo_word", got, 32'hBBCCDD00);
        applyStimulus(32'h204, 32'h0, RAM_MODE_WORD, RAM_MODE_NONE, 1'b0, got, lat, mExp, mLat);
        checkOutput("rstsplit_hi_word", got, 32'h00000000);

        // Randomized accesses in a prefilled window, upper address bits random
        for (int w = 0; w < 64; w++) begin
            applyStimulus(32'h1000 + 32'(4 * w), $urandom, RAM_MODE_NONE, RAM_MODE_WORD, 1'b0,
                          got, lat, mExp, mLat);
        end
        for (int i = 0; i < 300; i++) begin
            a  = {16'($urandom), 16'(32'h1000 + $urandom_range(0, 32'hF7))};
            d  = $urandom;
            rs = 2'($urandom_range(0, 3));
            ws = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            applyStimulus(a, d, rs, ws, sg, got, lat, mExp, mLat);
            if (rs != RAM_MODE_NONE) begin
                checkOutput($sformatf("rand%0d_rdata", i), got, mExp);
                checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(mLat));
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("valid_pulse_count", 32'(validPulses), 32'(loadsIssued));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Data-memory access unit that consumes the decoder's memory-control outputs (`ram_read_size`, `ram_write_size`, `ram_read_signed`) together with the ALU-computed address and the store data.
- Drives a word-wide, byte-enabled synchronous RAM with one-cycle read latency.
- Returns load data aligned to bit 0 and sign- or zero-extended.
- Handles accesses that cross a word boundary by splitting them into two RAM accesses under a small state machine. Sits between the execute stage and data RAM.

Parameters:
ADDR_W, 14, RAM word-address width (RAM depth = 2^ADDR_W words of 32 bits)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
req_valid  in  1  request present this cycle
req_ready  out  1  unit can accept a request; handshake = req_valid & req_ready
addr  in  32  byte address
wdata  in  32  store data, right-aligned
read_size  in  2  RAM_MODE_NONE/BYTE/HALF/WORD
write_size  in  2  RAM_MODE_NONE/BYTE/HALF/WORD
read_signed  in  1  1 = sign-extend load result
rdata  out  32  load result, aligned and extended
rdata_valid  out  1  one-cycle pulse, rdata is valid
ram_addr  out  ADDR_W  RAM word address
ram_we  out  1  RAM write enable
ram_be  out  4  byte enables (bit i = byte lane i)
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- Clock and reset:
  - The clock is `clk`; the reset is `rst`, synchronous and active-high.
  - While rst=1: state=IDLE, rdata=0, rdata_valid=0, req_ready=0, ram_we=0, ram_be=0. Any pending split access is discarded.
- Access kind and misalignment:
  - Load if read_size!=NONE. Store if write_size!=NONE and read_size==NONE; both non-NONE is treated as load only.
  - Both NONE: the request is accepted with no RAM activity and no rdata_valid.
  - off=addr[1:0]; size bytes n = 1/2/4.
  - Misaligned (split) iff off+n>4, i.e. HALF at off=3, or WORD at off=1..3.
- Address and lane mapping:
  - Word index w = addr[ADDR_W+1:2]; upper address bits are ignored.
  - The second word is (w+1) mod 2^ADDR_W, so the last word wraps to 0.
  - mask8 = ((1<<n)-1)<<off (8 bits): low word uses be = mask8[3:0], high word uses be = mask8[7:4].
  - Store lane data = wdata rotated left by 8*off; the same rotated value is driven on both writes.
- States: IDLE, LD_DATA, LD_HI, ST_HI.
- IDLE:
  - req_ready=1. RAM outputs are driven combinationally from the request inputs in the acceptance cycle.
  - Addr, off, size and sign are latched for later phases.
  - Aligned store: ram_we=1 and ram_be/ram_wdata driven in the acceptance cycle; state stays IDLE (back-to-back stores at full rate).
  - Misaligned store: write the low word in the acceptance cycle, then go to ST_HI.
  - Aligned load: ram_addr=w, ram_we=0, then go to LD_DATA.
  - Misaligned load: ram_addr=w, then go to LD_HI.
- ST_HI:
  - req_ready=0; ram_addr=w+1, ram_we=1, be=mask8[7:4].
  - Next state IDLE.
- LD_HI:
  - req_ready=0; capture ram_rdata as the low word; ram_addr=w+1.
  - Next state LD_DATA.
- LD_DATA:
  - req_ready=0; form the 64-bit value {hi,lo} (aligned case: hi=0, lo=ram_rdata).
  - Shift right by 8*off, take the low n bytes, and extend per the latched sign.
  - Register the result into rdata; next state IDLE.
  - rdata_valid=1 for exactly the following cycle, in which req_ready is already 1.
- Latency, counted from the acceptance cycle T:
  - Aligned load: rdata_valid at T+2.
  - Split load: rdata_valid at T+3.
  - Stores: write at T (aligned), or at T and T+1 (split).
- rdata holds its last value between loads.
- ram_wdata is don't-care while ram_we=0; ram_be=0 whenever no access is made.
- The requester holds the request inputs only during the handshake cycle; the unit depends only on its latched copies afterwards.

Decomposition:
- RAM_MODE_NONE=2'd0, BYTE=2'd1, HALF=2'd2, WORD=2'd3 go in the shared define header already used by the decoder.
- State encoding stays local to this module.
- One combinational sub-module is natural: load_align_ext (64-bit in, off, size, signed -> 32-bit result). It is reusable by the bench's reference model.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF -> same cycle: ram_we=1, be=1111, ram_addr=0x40, ram_wdata=0xDEADBEEF. Then LW 0x100 at T -> rdata_valid at T+2 with rdata=0xDEADBEEF.
- Word 0x40 holds 0x80FF0000; LB 0x103 -> rdata 0xFFFFFF80; LBU 0x103 -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
- SH addr 0x103, wdata 0x0000ABCD -> T: addr 0x40, be 1000, wdata 0xCD0000AB. T+1: addr 0x41, be 0001, same data, req_ready=0. T+2: req_ready=1.
- Words 0x40=0x44332211, 0x41=0x88776655; LW 0x102 -> ram_addr 0x40 at T, 0x41 at T+1; req_ready=0 at T+1 and T+2; rdata_valid at T+3 with rdata=0x66554433.
- LW at byte address 0xFFFD (w=0x3FFF, off=1) -> second access ram_addr=0x0000.
- Split store accepted at T with rst=1 at T+1 -> no ram_we at T+1, rdata_valid=0, req_ready=1 in the first cycle after rst returns low.
